imem_fetch_unit: RTL
====================

IMEM_FETCH_UNIT -- requirements
Module: imem_fetch_unit

Interface
REQ-001 Parameter DATA_W, default 32: instruction word width in bits; SHALL be a multiple of 8.
REQ-002 Parameter ADDR_W, default 32: byte-address width.
REQ-003 Parameter DEPTH, default 1024: number of words; SHALL be a power of two, at least 4.
REQ-004 Parameter NOP_WORD, default all-zero: fill and fault word.
REQ-005 clk  in  1: single clock; all state updates on the rising edge.
REQ-006 reset  in  1: asynchronous, active-high reset.
REQ-007 fetch_valid  in  1: fetch request present.
REQ-008 fetch_ready  out  1: fetch request can be accepted.
REQ-009 fetch_addr  in  ADDR_W: byte address of the requested instruction.
REQ-010 rsp_valid  out  1: response present.
REQ-011 rsp_ready  in  1: consumer accepts the response.
REQ-012 rsp_instr  out  DATA_W: fetched instruction word.
REQ-013 rsp_fault  out  2: fault code; 00 = ok, 01 = misaligned, 10 = out of range.
REQ-014 load_en  in  1: program-load write strobe.
REQ-015 load_addr  in  ADDR_W: byte address of the word to write.
REQ-016 load_data  in  DATA_W: word to write.
REQ-017 load_ready  out  1: load port accepting writes.

Function
REQ-018 Word index SHALL be addr[OFS+log2(DEPTH)-1:OFS], where OFS = log2(DATA_W/8).
REQ-019 FSM states SHALL be INIT, IDLE and RESP.
REQ-020 INIT: a counter SHALL write NOP_WORD to words 0..DEPTH-1, one word per cycle, then move to IDLE; INIT therefore lasts exactly DEPTH cycles.
REQ-021 During INIT: fetch_ready=0, load_ready=0, and load_en is ignored.
REQ-022 A fetch is accepted when fetch_valid && fetch_ready.
REQ-023 Read latency SHALL be 1 cycle: accept in cycle N gives rsp_valid=1 in cycle N+1, state RESP.
REQ-024 In RESP, rsp_valid, rsp_instr and rsp_fault SHALL hold stable until rsp_ready=1.
REQ-025 fetch_ready SHALL be 1 in IDLE, or in RESP when rsp_ready=1, giving one fetch per cycle of throughput.
REQ-026 RESP with rsp_ready=1 and no new fetch accepted SHALL return to IDLE.
REQ-027 Misaligned fetch (addr[OFS-1:0] != 0) SHALL give rsp_fault=01 and rsp_instr=NOP_WORD.
REQ-028 Out-of-range fetch (addr >= DEPTH*DATA_W/8) SHALL give rsp_fault=10 and rsp_instr=NOP_WORD.
REQ-029 If both fault conditions hold, misaligned (01) SHALL take precedence.
REQ-030 Load: when load_en && load_ready, load_data SHALL be written at the load_addr word.
REQ-031 A misaligned or out-of-range load SHALL be dropped silently.
REQ-032 load_ready SHALL be 1 in IDLE and in RESP.
REQ-033 Fetch and load accepted in the same cycle to the same word: the response SHALL carry the old data (read-before-write); the next fetch sees the new data.
REQ-034 Address decode SHALL not wrap: high address bits above the index range count as out of range.

Reset
REQ-035 Asserting reset SHALL force state INIT, init counter 0, rsp_valid=0, rsp_instr=NOP_WORD, rsp_fault=00, fetch_ready=0 and load_ready=0.
REQ-036 Reset asserted mid-response or mid-INIT SHALL drop any pending response, and the full INIT sweep SHALL restart after release.
REQ-037 Memory contents SHALL not be reset directly; they are cleared only by the INIT sweep.

Structure
REQ-038 A shared package SHALL hold the state enum (INIT, IDLE, RESP), the fault-code constants (FAULT_OK, FAULT_MISALIGN, FAULT_RANGE) and the default NOP_WORD.
REQ-039 The storage array SHALL be one sub-module, imem_sp_ram: one synchronous read port, one write port, read-before-write behaviour.
REQ-040 The FSM, address decode and fault logic SHALL live in imem_fetch_unit.

Verification
REQ-041 Reset release, DEPTH=16: fetch_ready=0 for exactly 16 cycles, then 1; fetch 0x0 gives rsp_instr=0x00000000, fault 00.
REQ-042 After INIT: load 0x20220005 @0x4, then fetch 0x4 gives 0x20220005 one cycle after accept.
REQ-043 Fetch 0x6 gives fault 01; fetch 0x40 (DEPTH=16) gives fault 10; both return NOP_WORD.
REQ-044 Back-to-back fetches 0x0, 0x4, 0x8 with rsp_ready held 1: three responses in consecutive cycles. Then rsp_ready=0 for 3 cycles: response held stable and fetch_ready=0.
REQ-045 Same-cycle load 0xAAAA5555 @0x8 and fetch 0x8: response is the old value; a refetch returns 0xAAAA5555.
REQ-046 Reset pulse while rsp_valid=1: rsp_valid falls immediately (asynchronous), INIT reruns, and previously loaded words read back as NOP_WORD.

Source files
------------

// File: rtl/imem_fetch_unit_pkg.sv
// Shared types and constants for the instruction-memory fetch unit.
package imem_fetch_unit_pkg;

  typedef enum logic [1:0] {
    INIT = 2'd0,
    IDLE = 2'd1,
    RESP = 2'd2
  } fetch_state_t;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Wide default so any DATA_W up to 64 can take a slice of it.
  localparam logic [63:0] DEFAULT_NOP_WORD = 64'h0;

  // Misalignment wins over out-of-range when both hold.
  function automatic logic [1:0] fault_code(input logic misaligned, input logic out_of_range);
    if (misaligned) return FAULT_MISALIGN;
    if (out_of_range) return FAULT_RANGE;
    return FAULT_OK;
  endfunction

endpackage

// File: rtl/imem_fetch_unit_if.sv
// Fetch/response/load bus of the instruction-memory fetch unit.
// Handshake rule for every channel: a transfer happens on the rising edge
// where valid && ready; the producer holds valid and its payload stable
// until that edge, and ready may depend combinationally on the other side.
interface imem_fetch_unit_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              fetch_valid;
  logic              fetch_ready;
  logic [ADDR_W-1:0] fetch_addr;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_instr;
  logic [1:0]        rsp_fault;
  logic              load_en;
  logic [ADDR_W-1:0] load_addr;
  logic [DATA_W-1:0] load_data;
  logic              load_ready;

  modport master (
    output fetch_valid, fetch_addr, rsp_ready, load_en, load_addr, load_data,
    input  fetch_ready, rsp_valid, rsp_instr, rsp_fault, load_ready
  );

  modport slave (
    input  fetch_valid, fetch_addr, rsp_ready, load_en, load_addr, load_data,
    output fetch_ready, rsp_valid, rsp_instr, rsp_fault, load_ready
  );
endinterface

// File: rtl/imem_sp_ram.sv
// Word storage: one synchronous read port, one write port. A read and a
// write to the same word in one cycle return the old contents.
module imem_sp_ram #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 1024,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rd_en,
  input  logic [IDX_W-1:0]  rd_addr,
  output logic [DATA_W-1:0] rd_data,
  input  logic              wr_en,
  input  logic [IDX_W-1:0]  wr_addr,
  input  logic [DATA_W-1:0] wr_data
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Write port; contents are deliberately never reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Registered read that holds its value while rd_en is low.
  always_ff @(posedge clk) begin
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/imem_fetch_unit.sv
// Instruction fetch unit: clears memory after reset, then serves 1-cycle
// fetches with fault reporting and accepts program-load writes.
module imem_fetch_unit
  import imem_fetch_unit_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 1024,
  parameter logic [DATA_W-1:0] NOP_WORD = DATA_W'(DEFAULT_NOP_WORD)
) (
  input  logic                clk,
  input  logic                reset,
  imem_fetch_unit_if.slave    bus,
  output fetch_state_t        state_dbg
);

  localparam int OFS   = $clog2(DATA_W / 8);
  localparam int IDX_W = $clog2(DEPTH);
  localparam logic [ADDR_W-1:0] OFS_MASK = ADDR_W'((64'd1 << OFS) - 64'd1);

  fetch_state_t      state_q, state_d;
  logic [IDX_W-1:0]  init_cnt_q;
  logic [1:0]        fault_q, fault_d;
  logic [IDX_W-1:0]  f_idx, l_idx;
  logic              l_ok;
  logic              accept;
  logic              fetch_ready, load_ready, rsp_valid;
  logic              ram_rd_en, ram_wr_en;
  logic [IDX_W-1:0]  ram_wr_addr;
  logic [DATA_W-1:0] ram_wr_data, ram_rd_data;

  // Address decode: bits above the index range never wrap, they fault.
  always_comb begin
    f_idx   = bus.fetch_addr[OFS +: IDX_W];
    l_idx   = bus.load_addr[OFS +: IDX_W];
    fault_d = fault_code(|(bus.fetch_addr & OFS_MASK),
                         (bus.fetch_addr >> (OFS + IDX_W)) != '0);
    l_ok    = ~|(bus.load_addr & OFS_MASK) &&
              ((bus.load_addr >> (OFS + IDX_W)) == '0);
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_d     = state_q;
    fetch_ready = 1'b0;
    load_ready  = 1'b0;
    rsp_valid   = 1'b0;
    case (state_q)
      INIT: begin
        if (init_cnt_q == IDX_W'(DEPTH - 1)) state_d = IDLE;
      end
      IDLE: begin
        fetch_ready = 1'b1;
        load_ready  = 1'b1;
        if (bus.fetch_valid) state_d = RESP;
      end
      RESP: begin
        load_ready  = 1'b1;
        rsp_valid   = 1'b1;
        fetch_ready = bus.rsp_ready;
        if (bus.rsp_ready && !bus.fetch_valid) state_d = IDLE;
      end
      default: state_d = INIT;
    endcase
  end

  assign accept = bus.fetch_valid && fetch_ready;

  // State, clear-sweep counter and fault code of the pending response.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= INIT;
      init_cnt_q <= '0;
      fault_q    <= FAULT_OK;
    end else begin
      state_q <= state_d;
      if (state_q == INIT) init_cnt_q <= init_cnt_q + 1'b1;
      if (accept) fault_q <= fault_d;
    end
  end

  // Memory write source: the clear sweep owns the port during INIT.
  always_comb begin
    ram_rd_en   = accept && (fault_d == FAULT_OK);
    ram_wr_en   = 1'b0;
    ram_wr_addr = l_idx;
    ram_wr_data = bus.load_data;
    if (state_q == INIT) begin
      ram_wr_en   = 1'b1;
      ram_wr_addr = init_cnt_q;
      ram_wr_data = NOP_WORD;
    end else if (bus.load_en && load_ready && l_ok) begin
      ram_wr_en = 1'b1;
    end
  end

  imem_sp_ram #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_ram (
    .clk     (clk),
    .rd_en   (ram_rd_en),
    .rd_addr (f_idx),
    .rd_data (ram_rd_data),
    .wr_en   (ram_wr_en),
    .wr_addr (ram_wr_addr),
    .wr_data (ram_wr_data)
  );

  assign bus.fetch_ready = fetch_ready;
  assign bus.load_ready  = load_ready;
  assign bus.rsp_valid   = rsp_valid;
  assign bus.rsp_fault   = fault_q;
  // Faulted or absent responses always carry the NOP word.
  assign bus.rsp_instr   = (rsp_valid && fault_q == FAULT_OK) ? ram_rd_data : NOP_WORD;
  assign state_dbg       = state_q;

endmodule
